// File: rtl/mux_scan_pkg.sv
//------------------------------------------------------------------------------
// mux_scan_pkg
//   Shared encodings and helpers for the mux_scan slice: mode encodings,
//   FSM state encoding and a constant log2 helper for port sizing.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_scan_pkg;

  // Value of the mode input selecting each operating mode
  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  // Top-level control states, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAN  = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  // Ceiling log2, clamped to at least 1 so derived vectors never collapse
  // to zero width (e.g. a dwell of 1 still needs a 1-bit counter).
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage : mux_scan_pkg

`default_nettype wire

// File: rtl/mux_dwell_cnt.sv
//------------------------------------------------------------------------------
// mux_dwell_cnt
//   Dwell counter for the auto-scan mode. Counts enabled cycles from 0 to
//   DWELL-1, wraps to 0 and flags the terminal cycle combinationally so the
//   owner can advance its channel on the same edge the count wraps.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter  int DWELL = 16,
  localparam int CW    = clog2_min1(DWELL)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,   // count this cycle
  input  logic clr_i,  // restart from 0, wins over en_i
  output logic tc_o    // this enabled cycle is the last of the dwell
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: clear, wrap at the terminal value, or step by one
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mux_dwell_cnt

`default_nettype wire

// File: rtl/mux_scan.sv
//------------------------------------------------------------------------------
// mux_scan
//   Registered N-to-1 multiplexer of W-bit channels with manual select and
//   auto-scan modes. Every output is a flop; the channel tag, valid flag,
//   out-of-range select flag and rotation-wrap pulse travel with the data.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int DWELL = 16,
  localparam int SW    = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  din,
  output logic [W-1:0]    o,
  output logic [SW-1:0]   o_ch,
  output logic            o_valid,
  output logic            sel_err,
  output logic            wrap
);

  // Select space rounded up to a power of two; slots >= N read as zero and
  // are flagged illegal so an out-of-range select never indexes past din.
  localparam int              NP      = 1 << SW;
  localparam logic [NP-1:0]   LEGAL   = NP'((1 << N) - 1);
  localparam logic [SW-1:0]   LAST_CH = SW'(N - 1);
  localparam logic [SW-1:0]   ONE_CH  = SW'(1);

  logic [W-1:0]  ch_data [NP];

  state_e        state_q;
  logic [SW-1:0] ch_q;       // scan channel to be sampled next
  logic          pend_q;     // scan rolled N-1 -> 0; flag it with the ch 0 sample
  logic [W-1:0]  o_q;
  logic [SW-1:0] o_ch_q;
  logic          o_valid_q;
  logic          sel_err_q;
  logic          wrap_q;

  logic          w_sel_ok;
  logic [SW-1:0] w_scan_ch;
  logic          w_tc;
  logic          w_cnt_en;
  logic          w_cnt_clr;

  generate
    for (genvar k = 0; k < NP; k++) begin : g_chan
      if (k < N) begin : g_live
        assign ch_data[k] = din[k*W +: W];
      end else begin : g_pad
        assign ch_data[k] = '0;
      end
    end
  endgenerate

  assign w_sel_ok  = LEGAL[sel];
  // Any scan entry starts from channel 0, whatever ch_q last held
  assign w_scan_ch = (state_q == ST_SCAN) ? ch_q : '0;

  // The dwell count only runs in scan; manual mode keeps it parked at 0 so
  // the next scan entry gets a full first dwell on channel 0.
  assign w_cnt_en  = en && (mode == MODE_SCAN);
  assign w_cnt_clr = en && (mode == MODE_MAN);

  mux_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_cnt_en),
    .clr_i (w_cnt_clr),
    .tc_o  (w_tc)
  );

  // Control FSM with registered data, tag, status and wrap outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      pend_q    <= 1'b0;
      o_q       <= '0;
      o_ch_q    <= '0;
      o_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (!en) begin
      // Frozen; only the wrap pulse drops so it never stretches
      wrap_q <= 1'b0;
    end else if (mode == MODE_MAN) begin
      state_q <= ST_MAN;
      ch_q    <= '0;
      pend_q  <= 1'b0;
      wrap_q  <= 1'b0;
      if (w_sel_ok) begin
        o_q       <= ch_data[sel];
        o_ch_q    <= sel;
        o_valid_q <= 1'b1;
        sel_err_q <= 1'b0;
      end else begin
        o_valid_q <= 1'b0;
        sel_err_q <= 1'b1;
      end
    end else begin
      state_q   <= ST_SCAN;
      o_q       <= ch_data[w_scan_ch];
      o_ch_q    <= w_scan_ch;
      o_valid_q <= 1'b1;
      // A rollover seen on the previous edge is reported alongside the
      // first channel-0 sample, so wrap lines up with o_ch going to 0.
      wrap_q    <= (state_q == ST_SCAN) && pend_q;
      if (w_tc) begin
        ch_q   <= (w_scan_ch == LAST_CH) ? '0 : w_scan_ch + ONE_CH;
        pend_q <= (w_scan_ch == LAST_CH);
      end else begin
        ch_q   <= w_scan_ch;
        pend_q <= 1'b0;
      end
    end
  end

  assign o       = o_q;
  assign o_ch    = o_ch_q;
  assign o_valid = o_valid_q;
  assign sel_err = sel_err_q;
  assign wrap    = wrap_q;

endmodule : mux_scan

`default_nettype wire
